// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR scrambler family: the mode encodings and
// the W-step unroll used by the datapath.
package lfsr_pkg;

  localparam logic [1:0] LFSR_MODE_ADD   = 2'd0;
  localparam logic [1:0] LFSR_MODE_MSCR  = 2'd1;
  localparam logic [1:0] LFSR_MODE_MDSCR = 2'd2;

  // Widest state and data the unroll supports. Narrower instances
  // zero-extend their operands and ignore the upper result bits.
  localparam int LFSR_MAX_W = 64;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] state;
    logic [LFSR_MAX_W-1:0] data;
  } lfsr_res_t;

  // Runs w serial steps from state s_in. Bit 0 of the data is the earliest
  // bit in time. The feedback bit enters at the top of the n-bit state.
  // Mode 3 falls through to the additive rule.
  function automatic lfsr_res_t lfsr_unroll(
    input logic [LFSR_MAX_W-1:0] s_in,
    input logic [LFSR_MAX_W-1:0] d_in,
    input logic [LFSR_MAX_W-1:0] poly,
    input logic [1:0]            mode,
    input int                    n,
    input int                    w
  );
    logic [LFSR_MAX_W-1:0] s;
    logic                  key;
    logic                  fb;
    lfsr_res_t             r;
    s = s_in;
    r = '0;
    for (int k = 0; k < LFSR_MAX_W; k++) begin
      if (k < w) begin
        key       = ^(s & poly);
        r.data[k] = d_in[k] ^ key;
        case (mode)
          LFSR_MODE_MSCR:  fb = r.data[k];
          LFSR_MODE_MDSCR: fb = d_in[k];
          default:         fb = key;
        endcase
        s = (s >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (n - 1));
      end
    end
    r.state = s;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational W-bit LFSR step: next state and scrambled/descrambled data
// for one beat. Kept standalone so the PRBS checker can reuse it.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int                  p_POLY_SIZE      = 16,
  parameter logic [p_POLY_SIZE-1:0] p_POLYNOMIAL  = 16'b1000_0000_0001_1100,
  parameter int                  p_BITS_PER_CLOCK = 8
) (
  input  logic [p_POLY_SIZE-1:0]      state,
  input  logic [p_BITS_PER_CLOCK-1:0] data_in,
  input  logic [1:0]                  mode,
  output logic [p_POLY_SIZE-1:0]      next_state,
  output logic [p_BITS_PER_CLOCK-1:0] data_out
);

  lfsr_res_t        res;
  logic [127:0]     res_unused;

  // Whole unroll evaluated in one cycle.
  always_comb begin
    res = lfsr_unroll(LFSR_MAX_W'(state), LFSR_MAX_W'(data_in),
                      LFSR_MAX_W'(p_POLYNOMIAL), mode,
                      p_POLY_SIZE, p_BITS_PER_CLOCK);
  end

  assign next_state = res.state[p_POLY_SIZE-1:0];
  assign data_out   = res.data[p_BITS_PER_CLOCK-1:0];
  // Upper bits beyond N/W are always zero and intentionally dropped.
  assign res_unused = res;

endmodule

// File: rtl/lfsr_stream_scrambler.sv
// Streaming LFSR scrambler/descrambler with seed register, per-frame reseed
// in additive mode and a sticky all-zero lockup flag.
//
// Handshake: a beat transfers on any rising edge where VALID and READY are
// both high. o_READY = ~o_VALID | i_READY, so a held output (o_VALID high,
// i_READY low) blocks new input, freezes the state and keeps o_DATA_OUT,
// o_SOF and o_STATE_OUT stable. Latency from acceptance to output is 1 cycle.
module lfsr_stream_scrambler
  import lfsr_pkg::*;
#(
  parameter int                     p_POLY_SIZE      = 16,
  parameter logic [p_POLY_SIZE-1:0] p_POLYNOMIAL     = 16'b1000_0000_0001_1100,
  parameter int                     p_BITS_PER_CLOCK = 8,
  parameter logic [p_POLY_SIZE-1:0] p_RESET_SEED     = 16'hFFFF
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET,
  input  logic [1:0]                  i_MODE,
  input  logic                        i_SEED_LOAD,
  input  logic [p_POLY_SIZE-1:0]      i_SEED,
  input  logic                        i_VALID,
  output logic                        o_READY,
  input  logic                        i_SOF,
  input  logic [p_BITS_PER_CLOCK-1:0] i_DATA_IN,
  output logic                        o_VALID,
  input  logic                        i_READY,
  output logic [p_BITS_PER_CLOCK-1:0] o_DATA_OUT,
  output logic                        o_SOF,
  output logic [p_POLY_SIZE-1:0]      o_STATE_OUT,
  output logic                        o_LOCKUP
);

  logic [p_POLY_SIZE-1:0]      r_state;
  logic [p_POLY_SIZE-1:0]      r_seed;
  logic [p_POLY_SIZE-1:0]      seed_eff;
  logic [p_POLY_SIZE-1:0]      start_state;
  logic [p_POLY_SIZE-1:0]      next_state;
  logic [p_BITS_PER_CLOCK-1:0] r_data;
  logic [p_BITS_PER_CLOCK-1:0] step_data;
  logic                        r_valid;
  logic                        r_sof;
  logic                        r_lockup;
  logic                        accept;
  logic                        mode_add;

  assign o_READY  = ~r_valid | i_READY;
  assign accept   = i_VALID & o_READY;
  // Reserved mode 3 behaves as additive.
  assign mode_add = (i_MODE != LFSR_MODE_MSCR) && (i_MODE != LFSR_MODE_MDSCR);
  // A seed load on the same cycle as an SOF beat is bypassed into that beat.
  assign seed_eff    = i_SEED_LOAD ? i_SEED : r_seed;
  assign start_state = (i_SOF && mode_add) ? seed_eff : r_state;

  lfsr_step #(
    .p_POLY_SIZE      (p_POLY_SIZE),
    .p_POLYNOMIAL     (p_POLYNOMIAL),
    .p_BITS_PER_CLOCK (p_BITS_PER_CLOCK)
  ) u_step (
    .state      (start_state),
    .data_in    (i_DATA_IN),
    .mode       (i_MODE),
    .next_state (next_state),
    .data_out   (step_data)
  );

  // Seed register, LFSR state, output register and sticky lockup flag.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state  <= p_RESET_SEED;
      r_seed   <= p_RESET_SEED;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sof    <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      if (i_SEED_LOAD) begin
        r_seed <= i_SEED;
      end
      if (accept) begin
        r_state <= next_state;
        r_data  <= step_data;
        r_sof   <= i_SOF;
        r_valid <= 1'b1;
        if (mode_add && (next_state == '0)) begin
          r_lockup <= 1'b1;
        end
      end else if (i_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_VALID     = r_valid;
  assign o_DATA_OUT  = r_data;
  assign o_SOF       = r_sof;
  assign o_STATE_OUT = r_state;
  assign o_LOCKUP    = r_lockup;

endmodule

// File: tb/tb_lfsr_stream_scrambler.sv
// Bench for lfsr_stream_scrambler: a small N=4/W=4 instance with hand-worked
// vectors, and a default-parameter scrambler feeding a descrambler.
module tb_lfsr_stream_scrambler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- small instance (N=4, W=4) ----------------
  logic       rst4, a_sl, a_valid, a_o_ready, a_sof, a_o_valid, a_o_sof, a_o_lock;
  logic [1:0] a_mode;
  logic [3:0] a_seed, a_data, a_o_data, a_o_state;

  lfsr_stream_scrambler #(
    .p_POLY_SIZE(4), .p_POLYNOMIAL(4'b0011), .p_BITS_PER_CLOCK(4), .p_RESET_SEED(4'b0001)
  ) dut4 (
    .i_CLK(clk), .i_RESET(rst4), .i_MODE(a_mode), .i_SEED_LOAD(a_sl), .i_SEED(a_seed),
    .i_VALID(a_valid), .o_READY(a_o_ready), .i_SOF(a_sof), .i_DATA_IN(a_data),
    .o_VALID(a_o_valid), .i_READY(1'b1), .o_DATA_OUT(a_o_data), .o_SOF(a_o_sof),
    .o_STATE_OUT(a_o_state), .o_LOCKUP(a_o_lock)
  );

  // ---------------- default scrambler -> descrambler ----------------
  logic        rst16, s_sl, s_valid, s_o_ready, s_sof, s_o_valid, s_o_sof, s_o_lock;
  logic [1:0]  s_mode;
  logic [15:0] s_seed, s_o_state, d_o_state;
  logic [7:0]  s_data, s_o_data, d_o_data;
  logic        d_o_ready, d_o_valid, d_o_sof, d_o_lock, d_rdy;

  lfsr_stream_scrambler dut_s (
    .i_CLK(clk), .i_RESET(rst16), .i_MODE(s_mode), .i_SEED_LOAD(s_sl), .i_SEED(s_seed),
    .i_VALID(s_valid), .o_READY(s_o_ready), .i_SOF(s_sof), .i_DATA_IN(s_data),
    .o_VALID(s_o_valid), .i_READY(d_o_ready), .o_DATA_OUT(s_o_data), .o_SOF(s_o_sof),
    .o_STATE_OUT(s_o_state), .o_LOCKUP(s_o_lock)
  );

  lfsr_stream_scrambler #(.p_RESET_SEED(16'h5A5A)) dut_d (
    .i_CLK(clk), .i_RESET(rst16), .i_MODE(2'd2), .i_SEED_LOAD(1'b0), .i_SEED(16'h0000),
    .i_VALID(s_o_valid), .o_READY(d_o_ready), .i_SOF(s_o_sof), .i_DATA_IN(s_o_data),
    .o_VALID(d_o_valid), .i_READY(d_rdy), .o_DATA_OUT(d_o_data), .o_SOF(d_o_sof),
    .o_STATE_OUT(d_o_state), .o_LOCKUP(d_o_lock)
  );

  // ---------------- scoreboard queues and reference model state ----------------
  logic [9:0]  exp4_q[$];   // {lock, state[3:0], sof, data[3:0]}
  logic [25:0] exp16_q[$];  // {lock, state[15:0], sof, data[7:0]}
  logic [8:0]  desc_q[$];   // {check_enable, original data[7:0]}

  logic [3:0]  m4_s, m4_seed;
  logic        m4_lock;
  logic [15:0] ms_s, ms_seed;
  logic        ms_lock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: key is the parity of the tapped state bits, the
  // new bit enters at position n-1 while everything moves one place down.
  function automatic logic [127:0] ref_beat(input logic [63:0] s, input logic [63:0] d,
                                            input logic [63:0] poly, input int n,
                                            input int w, input int mode);
    logic [63:0] o = '0;
    int key, in_b, fb;
    for (int k = 0; k < w; k++) begin
      key  = $countones(s & poly) % 2;
      in_b = int'((d >> k) & 64'd1);
      o    = o | (64'(in_b ^ key) << k);
      fb   = (mode == 1) ? (in_b ^ key) : (mode == 2) ? in_b : key;
      s    = (s >> 1) | (64'(fb) << (n - 1));
    end
    return {s, o};
  endfunction

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send4(input logic [3:0] d, input logic sof, input logic sl,
                       input logic [3:0] seed, input logic [1:0] mode);
    logic [3:0]   s0;
    logic [127:0] r;
    logic         add;
    int           guard = 0;
    a_valid = 1'b1; a_data = d; a_sof = sof; a_sl = sl; a_seed = seed; a_mode = mode;
    @(negedge clk);
    while (!a_o_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!a_o_ready) begin
      chk("dut4 accept timeout", 64'(a_o_ready), 64'd1);
    end else begin
      add = (mode == 2'd0) || (mode == 2'd3);
      s0  = (add && sof) ? (sl ? seed : m4_seed) : m4_s;
      if (sl) m4_seed = seed;
      r    = ref_beat(64'(s0), 64'(d), 64'h3, 4, 4, int'(mode));
      m4_s = r[67:64];
      if (add && m4_s == 4'd0) m4_lock = 1'b1;
      exp4_q.push_back({m4_lock, m4_s, sof, r[3:0]});
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_sof = 1'b0; a_sl = 1'b0;
  endtask

  task automatic send16(input logic [7:0] d, input logic sof, input logic sl,
                        input logic [15:0] seed, input logic [1:0] mode, input logic chk_desc);
    logic [15:0]  s0;
    logic [127:0] r;
    logic         add;
    int           guard = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_sl = sl; s_seed = seed; s_mode = mode;
    @(negedge clk);
    while (!s_o_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!s_o_ready) begin
      chk("dut_s accept timeout", 64'(s_o_ready), 64'd1);
    end else begin
      add = (mode == 2'd0) || (mode == 2'd3);
      s0  = (add && sof) ? (sl ? seed : ms_seed) : ms_s;
      if (sl) ms_seed = seed;
      r    = ref_beat(64'(s0), 64'(d), 64'h801C, 16, 8, int'(mode));
      ms_s = r[79:64];
      if (add && ms_s == 16'd0) ms_lock = 1'b1;
      exp16_q.push_back({ms_lock, ms_s, sof, r[7:0]});
      if (mode == 2'd1) desc_q.push_back({chk_desc, d});
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_sl = 1'b0;
  endtask

  // ---------------- monitors ----------------
  // Small instance is always ready downstream: every valid cycle is a transfer.
  always @(negedge clk) begin
    logic [9:0] e;
    if (a_o_valid) begin
      if (exp4_q.size() == 0) begin
        chk("dut4 unexpected beat", 64'd1, 64'd0);
      end else begin
        e = exp4_q.pop_front();
        chk("dut4 data",  64'(a_o_data),  64'(e[3:0]));
        chk("dut4 sof",   64'(a_o_sof),   64'(e[4]));
        chk("dut4 state", 64'(a_o_state), 64'(e[8:5]));
        chk("dut4 lockup", 64'(a_o_lock), 64'(e[9]));
      end
    end
  end

  // Scrambler output is compared every valid cycle, including stalled ones,
  // and retired only when the descrambler takes it.
  always @(negedge clk) begin
    logic [25:0] e;
    if (s_o_valid) begin
      if (exp16_q.size() == 0) begin
        chk("dut_s unexpected beat", 64'd1, 64'd0);
      end else begin
        e = exp16_q[0];
        chk("dut_s data",   64'(s_o_data),  64'(e[7:0]));
        chk("dut_s sof",    64'(s_o_sof),   64'(e[8]));
        chk("dut_s state",  64'(s_o_state), 64'(e[24:9]));
        chk("dut_s lockup", 64'(s_o_lock),  64'(e[25]));
        if (d_o_ready) void'(exp16_q.pop_front());
      end
    end
  end

  // Descrambled output must reproduce the original plaintext once synced.
  always @(negedge clk) begin
    logic [8:0] e;
    if (d_o_valid && d_rdy && desc_q.size() > 0) begin
      e = desc_q.pop_front();
      if (e[8]) chk("descrambled data", 64'(d_o_data), 64'(e[7:0]));
    end
  end

  // ---------------- stimulus ----------------
  logic chain_done;
  int   cyc;

  initial begin
    logic [7:0] dv;
    rst4 = 1'b1; rst16 = 1'b1; d_rdy = 1'b1; chain_done = 1'b0; cyc = 0;
    a_valid = 0; a_sof = 0; a_sl = 0; a_seed = 0; a_data = 0; a_mode = 0;
    s_valid = 0; s_sof = 0; s_sl = 0; s_seed = 0; s_data = 0; s_mode = 0;
    m4_s = 4'b0001; m4_seed = 4'b0001; m4_lock = 1'b0;
    ms_s = 16'hFFFF; ms_seed = 16'hFFFF; ms_lock = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst4 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    chk("reset dut4 valid",  64'(a_o_valid), 64'd0);
    chk("reset dut4 data",   64'(a_o_data),  64'd0);
    chk("reset dut4 state",  64'(a_o_state), 64'h1);
    chk("reset dut4 lockup", 64'(a_o_lock),  64'd0);
    chk("reset dut4 sof",    64'(a_o_sof),   64'd0);
    chk("reset dut_s state", 64'(s_o_state), 64'hFFFF);
    chk("reset dut_s valid", 64'(s_o_valid), 64'd0);
    @(posedge clk); #1;

    // Hand-worked additive vectors.
    send4(4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    chk("vec1 data", 64'(a_o_data), 64'h9);
    chk("vec1 state", 64'(a_o_state), 64'h9);
    send4(4'h0, 1'b0, 1'b0, 4'h0, 2'd0);
    chk("vec2 data", 64'(a_o_data), 64'h5);
    chk("vec2 state", 64'(a_o_state), 64'h5);

    // SOF restarts from the seed regardless of history and mode changes.
    for (int i = 0; i < 10; i++)
      send4(4'($urandom_range(0, 15)), 1'b0, 1'b0, 4'h0, 2'($urandom_range(0, 3)));
    send4(4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    chk("sof restart data", 64'(a_o_data), 64'h9);
    for (int i = 0; i < 5; i++)
      send4(4'($urandom_range(0, 15)), 1'b0, 1'b0, 4'h0, 2'd0);
    send4(4'h0, 1'b1, 1'b1, 4'b0001, 2'd0);
    chk("seed bypass data", 64'(a_o_data), 64'h9);
    send4(4'h0, 1'b1, 1'b1, 4'b0110, 2'd0);

    // Random mixed traffic on the small instance.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send4(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    // Reset with a beat in the output register.
    send4(4'($urandom_range(0, 15)), 1'b0, 1'b0, 4'h0, 2'd1);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("mid reset valid", 64'(a_o_valid), 64'd0);
    chk("mid reset state", 64'(a_o_state), 64'h1);
    chk("mid reset lockup", 64'(a_o_lock), 64'd0);
    m4_s = 4'b0001; m4_seed = 4'b0001; m4_lock = 1'b0;
    send4(4'h0, 1'b1, 1'b0, 4'h0, 2'd0);
    chk("post reset data", 64'(a_o_data), 64'h9);

    // Multiplicative scrambler into descrambler with random backpressure and
    // a guaranteed 3-cycle stall.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
          send16(8'($urandom_range(0, 255)), (i == 0), 1'b0, 16'h0, 2'd1, (i >= 2));
        end
        chain_done = 1'b1;
      end
      begin
        while (!chain_done) begin
          @(posedge clk); #1;
          cyc++;
          if (cyc >= 40 && cyc < 43) d_rdy = 1'b0;
          else d_rdy = ($urandom_range(0, 3) != 0);
        end
        d_rdy = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("chain scrambler queue drained", 64'(exp16_q.size()), 64'd0);
    chk("chain descrambler queue drained", 64'(desc_q.size()), 64'd0);

    // Lockup: all-zero seed in additive mode.
    dv = 8'($urandom_range(0, 255));
    send16(dv, 1'b1, 1'b1, 16'h0000, 2'd0, 1'b0);
    chk("lockup data passthrough", 64'(s_o_data), 64'(dv));
    chk("lockup flag set", 64'(s_o_lock), 64'd1);
    chk("lockup state zero", 64'(s_o_state), 64'd0);
    for (int i = 0; i < 3; i++) send16(8'($urandom_range(0, 255)), 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
    send16(8'h00, 1'b1, 1'b1, 16'hFFFF, 2'd0, 1'b0);
    chk("lockup sticky after reseed", 64'(s_o_lock), 64'd1);
    for (int i = 0; i < 4; i++) send16(8'($urandom_range(0, 255)), 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    chk("reset clears lockup", 64'(s_o_lock), 64'd0);
    chk("reset dut_s state again", 64'(s_o_state), 64'hFFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("dut4 queue drained", 64'(exp4_q.size()), 64'd0);
    chk("dut_s queue drained", 64'(exp16_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_scrambler.md
Name: lfsr_stream_scrambler

Overview:
- Parametrised successor to the fixed 16-bit, 8-bit/clock additive scrambler.
- Polynomial width and bits-per-clock are generic. Supports run-time mode select: additive (frame-synchronous), multiplicative scramble, and self-synchronising descramble.
- Streaming valid/ready handshake, run-time seed reload, per-frame reseed, and all-zero lockup detection.
- Sits between the framer and the line encoder in the TX path; the RX path uses a second instance in descramble mode.

Parameters:
- p_POLY_SIZE, 16, LFSR state width N (2..64).
- p_POLYNOMIAL, 16'b1000_0000_0001_1100, tap mask, N bits; bit j set = state bit j feeds back.
- p_BITS_PER_CLOCK, 8, data width W (1..64); bits processed per accepted beat.
- p_RESET_SEED, 16'hFFFF, N-bit seed loaded at reset.

Ports:
- i_CLK  in  1  clock
- i_RESET  in  1  synchronous active-high reset
- i_MODE  in  2  0 = additive, 1 = mult scramble, 2 = mult descramble, 3 = reserved (behaves as 0)
- i_SEED_LOAD  in  1  pulse: r_SEED <= i_SEED
- i_SEED  in  N  new seed value
- i_VALID  in  1  input beat valid
- o_READY  out  1  input beat accepted when i_VALID & o_READY
- i_SOF  in  1  start of frame, qualified by the beat
- i_DATA_IN  in  W  data; bit 0 is earliest in time
- o_VALID  out  1  output beat valid
- i_READY  in  1  downstream ready
- o_DATA_OUT  out  W  scrambled/descrambled data, registered
- o_SOF  out  1  i_SOF delayed with its beat
- o_STATE_OUT  out  N  current LFSR state S
- o_LOCKUP  out  1  sticky: additive state became all-zero

Behaviour:
- Reset (synchronous): S <= p_RESET_SEED; r_SEED <= p_RESET_SEED; o_VALID = 0; o_DATA_OUT = 0; o_SOF = 0; o_LOCKUP = 0.
- Serial model, per bit k = 0..W-1, in order:
  - key = ^(S & p_POLYNOMIAL)
  - out[k] = in[k] ^ key
  - Additive: S <= {key, S[N-1:1]}
  - Mult scramble: S <= {out[k], S[N-1:1]}
  - Mult descramble: S <= {in[k], S[N-1:1]}
- The whole W-bit unroll is combinational within one cycle.
- Handshake:
  - o_READY = ~o_VALID | i_READY.
  - On acceptance, the output register loads next cycle, so latency is 1 cycle.
  - Full throughput: 1 beat/clock with i_READY held high.
  - When o_VALID & ~i_READY, the output holds stable and S does not advance.
- S advances only on accepted beats; it does not change on idle cycles.
- i_SOF on an accepted beat in additive mode: the beat is processed from S = r_SEED, not the current S.
- i_SOF in multiplicative modes: ignored for state purposes; only forwarded on o_SOF.
- Seed load:
  - i_SEED_LOAD updates r_SEED only; it never touches S directly.
  - Simultaneous with an accepted SOF beat: the beat uses the new i_SEED value (bypass).
- i_MODE is sampled per accepted beat. Changing mode mid-frame is legal; the state continues under the new update rule.
- Lockup: additive mode with a post-beat state of all zeros sets o_LOCKUP (sticky until reset). S stays all-zero until the next SOF or reset; there is no auto-recovery.
- Reset mid-stream: the in-flight output beat is dropped (o_VALID = 0 next cycle).
- Descrambler self-syncs: after N input bits from a matching scrambler, output equals the original data regardless of the initial S.
- Width rule: any N, W combination is legal, including W > N.

Decomposition:
- Package lfsr_pkg:
  - mode constants LFSR_MODE_ADD = 2'd0, LFSR_MODE_MSCR = 2'd1, LFSR_MODE_MDSCR = 2'd2
  - a function computing the W-step key and next state for given S, data, polynomial and mode
- Sub-module lfsr_step (combinational): inputs S, data, mode; outputs next S and out data. It is reused by the PRBS checker next quarter.
- Top level: handshake register, seed register, SOF mux, lockup flag.

Test Plan:
- Override N = 4, POLY = 4'b0011, SEED = 4'b0001, W = 4, additive. Two beats of data 0, first with SOF -> o_DATA_OUT 4'h9 then 4'h5; o_STATE_OUT 4'b1001 then 4'b0101.
- Same config, SOF beat after 10 random beats -> output repeats 4'h9; seed load of 4'b0001 simultaneous with SOF gives the same 4'h9.
- Defaults, mult scramble instance feeding mult descramble instance with a different initial seed, 100 random beats -> descrambled output equals input from beat 2 onward (N = 16 ≤ 2 × 8 bits).
- Backpressure: i_READY low for 3 cycles mid-stream -> o_DATA_OUT stable, o_STATE_OUT unchanged, no beat lost or duplicated versus the golden model.
- Seed load i_SEED = 0, additive, SOF beat -> o_LOCKUP = 1 and o_DATA_OUT == i_DATA_IN. Next SOF after loading seed 16'hFFFF -> scrambling resumes while o_LOCKUP stays 1. i_RESET clears o_LOCKUP.
- Reset asserted with o_VALID = 1 -> o_VALID = 0 and o_STATE_OUT = p_RESET_SEED next cycle.
